// File: rtl/if_id_buffer.sv
// IF/ID pipeline register: pairs each fetched instruction with its optional immediate word
// and handles stall, flush and interrupt entry. Define PERF_CNT_EN to add stall/flush counters.
module if_id_buffer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [15:0] in_word,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_next_pc,
   input  logic        stall,
   input  logic        flush,
   input  logic        interruptBit,
   output logic        out_valid,
   output logic [15:0] out_instruction,
   output logic [15:0] out_immediate,
   output logic [31:0] out_pc,
   output logic [31:0] out_next_pc,
   output logic        out_int,
   output logic        imm_pending
`ifdef PERF_CNT_EN
   ,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count
`endif
);

   localparam int unsigned WORD_W = 16;
   localparam int unsigned PC_W   = 32;
   localparam logic [2:0]  OPC_IMM = 3'b001;

   typedef enum logic {WORD0, WORD1} state_t;

   state_t              r_state;
   logic [WORD_W-1:0]   r_hold_word;
   logic [PC_W-1:0]     r_hold_pc;

   state_t              w_state_nxt;
   logic [WORD_W-1:0]   w_hold_word_nxt;
   logic [PC_W-1:0]     w_hold_pc_nxt;
   logic                w_valid_nxt;
   logic [WORD_W-1:0]   w_instr_nxt;
   logic [WORD_W-1:0]   w_imm_nxt;
   logic [PC_W-1:0]     w_pc_nxt;
   logic [PC_W-1:0]     w_npc_nxt;
   logic                w_int_nxt;
   logic                w_needs_imm;

   assign w_needs_imm = (in_word[15:13] == OPC_IMM);

   // Next-state and next-output logic; priority flush > interrupt > stall > normal.
   always_comb begin
      w_state_nxt     = r_state;
      w_hold_word_nxt = r_hold_word;
      w_hold_pc_nxt   = r_hold_pc;
      w_valid_nxt     = out_valid;
      w_instr_nxt     = out_instruction;
      w_imm_nxt       = out_immediate;
      w_pc_nxt        = out_pc;
      w_npc_nxt       = out_next_pc;
      w_int_nxt       = out_int;

      if (flush) begin
         w_state_nxt = WORD0;
         w_valid_nxt = 1'b0;
         w_instr_nxt = '0;
         w_int_nxt   = 1'b0;
      end else if (interruptBit) begin
         // The bubble reports the oldest word not yet handed to decode as the return point.
         w_state_nxt = WORD0;
         w_valid_nxt = 1'b1;
         w_int_nxt   = 1'b1;
         w_instr_nxt = '0;
         w_imm_nxt   = '0;
         w_pc_nxt    = (r_state == WORD1) ? r_hold_pc : in_pc;
      end else if (stall) begin
         w_state_nxt = r_state;
      end else if (in_valid) begin
         w_int_nxt = 1'b0;
         if (r_state == WORD1) begin
            w_state_nxt = WORD0;
            w_valid_nxt = 1'b1;
            w_instr_nxt = r_hold_word;
            w_imm_nxt   = in_word;
            w_pc_nxt    = r_hold_pc;
            w_npc_nxt   = in_next_pc;
         end else if (w_needs_imm) begin
            w_state_nxt     = WORD1;
            w_valid_nxt     = 1'b0;
            w_hold_word_nxt = in_word;
            w_hold_pc_nxt   = in_pc;
         end else begin
            w_valid_nxt = 1'b1;
            w_instr_nxt = in_word;
            w_imm_nxt   = '0;
            w_pc_nxt    = in_pc;
            w_npc_nxt   = in_next_pc;
         end
      end else begin
         w_valid_nxt = 1'b0;
         w_int_nxt   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= WORD0;
         r_hold_word     <= '0;
         r_hold_pc       <= '0;
         out_valid       <= 1'b0;
         out_instruction <= '0;
         out_immediate   <= '0;
         out_pc          <= '0;
         out_next_pc     <= '0;
         out_int         <= 1'b0;
         imm_pending     <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_hold_word     <= w_hold_word_nxt;
         r_hold_pc       <= w_hold_pc_nxt;
         out_valid       <= w_valid_nxt;
         out_instruction <= w_instr_nxt;
         out_immediate   <= w_imm_nxt;
         out_pc          <= w_pc_nxt;
         out_next_pc     <= w_npc_nxt;
         out_int         <= w_int_nxt;
         imm_pending     <= (w_state_nxt == WORD1);
      end
   end

`ifdef PERF_CNT_EN
   logic w_stall_win;

   assign w_stall_win = stall && !flush && !interruptBit;

   // Saturating event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (w_stall_win && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'(1);
         if (flush && (flush_count != 16'hFFFF))
            flush_count <= flush_count + 16'(1);
      end
   end
`endif

endmodule
